// File: rtl/debug_uart_phy.sv
// Byte-level 8N1 UART PHY between the host pins and the debug bus master command stream.
// Optional stop-bit framing check enabled by defining DEBUG_UART_FRAME_CHECK_EN.
module debug_uart_phy #(
  parameter int CLKS_PER_BIT  = 417,
  parameter int TX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic [7:0] o_com_data,
  output logic       o_com_strobe,
  input  logic [7:0] i_com_data,
  input  logic       i_com_strobe,
  output logic       o_frame_error,
  output logic       o_tx_overflow,
  output logic       o_tx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(TX_FIFO_DEPTH - 1);
  localparam logic [PW-1:0] DEPTH_P  = PW'(TX_FIFO_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  rx_state_e     rx_state_q, rx_state_d;
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    com_data_q, com_data_d;
  logic          com_strobe_q, com_strobe_d;
  logic          rxs;
`ifdef DEBUG_UART_FRAME_CHECK_EN
  logic          frame_error_q, frame_error_d;
  logic          rx_break_q, rx_break_d;
`endif

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          uart_tx_q, uart_tx_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [7:0]    fifo_mem [TX_FIFO_DEPTH];
  logic          pop, push_ok;
  logic          unused_ptr_msb;

  assign rxs            = rx_sync_q[1];
  assign unused_ptr_msb = wr_ptr_q[PW-1] ^ rd_ptr_q[PW-1];

  // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    rx_sync_d    = {rx_sync_q[0], i_uart_rx};
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CW'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    com_data_d   = com_data_q;
    com_strobe_d = 1'b0;
`ifdef DEBUG_UART_FRAME_CHECK_EN
    frame_error_d = 1'b0;
    rx_break_d    = rx_break_q;
`endif
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
`ifdef DEBUG_UART_FRAME_CHECK_EN
        // After a framing error the line must go high before a new start bit counts.
        if (rx_break_q) begin
          if (rxs) rx_break_d = 1'b0;
        end else
`endif
        if (!rxs) begin
          rx_state_d = RX_START;
          rx_bit_d   = '0;
        end
      end
      RX_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_state_d = rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rxs, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'(1);
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
`ifdef DEBUG_UART_FRAME_CHECK_EN
        if (!rxs) begin
          frame_error_d = 1'b1;
          rx_break_d    = 1'b1;
        end else begin
          com_strobe_d = 1'b1;
          com_data_d   = rx_shift_q;
        end
`else
        com_strobe_d = 1'b1;
        com_data_d   = rx_shift_q;
`endif
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync_q    <= 2'b11;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      com_data_q   <= '0;
      com_strobe_q <= 1'b0;
    end else begin
      rx_sync_q    <= rx_sync_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      com_data_q   <= com_data_d;
      com_strobe_q <= com_strobe_d;
    end
  end

`ifdef DEBUG_UART_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_error_q <= 1'b0;
      rx_break_q    <= 1'b0;
    end else begin
      frame_error_q <= frame_error_d;
      rx_break_q    <= rx_break_d;
    end
  end
  assign o_frame_error = frame_error_q;
`else
  assign o_frame_error = 1'b0;
`endif

  always_comb begin
    pop        = 1'b0;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (count_q != '0) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 3'(1);
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        // Chain straight into the next frame when one is queued.
        if (count_q != '0) begin
          pop        = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    unique case (tx_state_d)
      TX_START: uart_tx_d = 1'b0;
      TX_DATA:  uart_tx_d = tx_shift_d[0];
      default:  uart_tx_d = 1'b1;
    endcase

    push_ok    = i_com_strobe && ((count_q != DEPTH_P) || pop);
    overflow_d = i_com_strobe && !push_ok;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + PW'(1);
    else if (pop && !push_ok) count_d = count_q - PW'(1);
    busy_d = (count_d != '0) || (tx_state_d != TX_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      uart_tx_q  <= uart_tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is left unreset; the count guarantees no stale entry is ever read.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= i_com_data;
  end

  assign o_uart_tx     = uart_tx_q;
  assign o_com_data    = com_data_q;
  assign o_com_strobe  = com_strobe_q;
  assign o_tx_overflow = overflow_q;
  assign o_tx_busy     = busy_q;
endmodule

// File: tb/tb_debug_uart_phy.sv
// Self-checking bench for debug_uart_phy: frame-level RX/TX model plus directed literal checks.
module tb_debug_uart_phy;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic [7:0] i_com_data = 8'h00;
  logic       i_com_strobe = 1'b0;
  logic       o_uart_tx, o_com_strobe, o_frame_error, o_tx_overflow, o_tx_busy;
  logic [7:0] o_com_data;

  always #5 clk = ~clk;

  debug_uart_phy #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx),
    .o_com_data(o_com_data), .o_com_strobe(o_com_strobe),
    .i_com_data(i_com_data), .i_com_strobe(i_com_strobe),
    .o_frame_error(o_frame_error), .o_tx_overflow(o_tx_overflow), .o_tx_busy(o_tx_busy)
  );

  int         tests = 0;
  int         fails = 0;
  int         strobe_cnt = 0;
  int         ovf_cnt = 0;
  int         ferr_cnt = 0;
  logic       strobe_prev = 1'b0;
  logic [7:0] rx_exp[$];
  logic       tx_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: received bytes against the expected queue, line level against expected samples.
  always @(negedge clk) begin
    if (o_com_strobe) begin
      strobe_cnt++;
      check("rx_strobe_width", {31'b0, strobe_prev}, 0);
      if (rx_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rx_unexpected: actual strobe with data %0h, required no strobe at %0t",
                 o_com_data, $time);
      end else begin
        check("rx_data", o_com_data, rx_exp.pop_front());
      end
    end
    strobe_prev = o_com_strobe;
    if (o_tx_overflow) ovf_cnt++;
    if (o_frame_error) ferr_cnt++;
    if (tx_exp.size() != 0) check("tx_line", o_uart_tx, tx_exp.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input bit expect_byte);
    if (expect_byte) rx_exp.push_back(b);
    i_uart_rx = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      i_uart_rx = b[k];
      tick(CPB);
    end
    i_uart_rx = stop_bit;
    tick(CPB);
  endtask

  // Expected line samples of one 8N1 frame, one sample per clock.
  task automatic queue_frame(input logic [7:0] b);
    logic bit_v;
    for (int n = 0; n < 10; n++) begin
      bit_v = (n == 0) ? 1'b0 : (n == 9) ? 1'b1 : b[n-1];
      repeat (CPB) tx_exp.push_back(bit_v);
    end
  endtask

  task automatic queue_idle(input int n);
    repeat (n) tx_exp.push_back(1'b1);
  endtask

  task automatic push(input logic [7:0] b);
    i_com_data   = b;
    i_com_strobe = 1'b1;
    tick(1);
    i_com_strobe = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((rx_exp.size() != 0 || tx_exp.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, rx_exp.size() + tx_exp.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s0, o0, f0;
    logic [9:0] lit_4b;
    lit_4b = 10'b1_01001011_0;

    // Reset values
    tick(2);
    check("rst_uart_tx", o_uart_tx, 1);
    check("rst_com_data", o_com_data, 0);
    check("rst_com_strobe", o_com_strobe, 0);
    check("rst_frame_error", o_frame_error, 0);
    check("rst_overflow", o_tx_overflow, 0);
    check("rst_busy", o_tx_busy, 0);
    rst_n = 1'b1;
    tick(2);

    // RX single frame, then back-to-back frames
    send_rx(8'h52, 1'b1, 1);
    tick(4);
    check("rx_r_count", strobe_cnt, 1);
    check("rx_r_hold", o_com_data, 8'h52);
    send_rx(8'h00, 1'b1, 1);
    send_rx(8'hFF, 1'b1, 1);
    tick(10);
    check("rx_b2b_count", strobe_cnt, 3);
    check("rx_b2b_last", o_com_data, 8'hFF);

    // Short low glitch
    i_uart_rx = 1'b0;
    tick(3);
    i_uart_rx = 1'b1;
    tick(20);
    check("rx_glitch_count", strobe_cnt, 3);
    send_rx(8'hA5, 1'b1, 1);
    tick(10);
    check("rx_after_glitch_count", strobe_cnt, 4);
    check("rx_after_glitch_data", o_com_data, 8'hA5);

    // TX single byte "K" with literal mid-bit samples and busy timing
    queue_idle(2);
    queue_frame(8'h4B);
    queue_idle(4);
    push(8'h4B);
    tick(5);
    for (int n = 0; n < 10; n++) begin
      check("tx_k_bit", o_uart_tx, lit_4b[n]);
      check("tx_k_busy", o_tx_busy, 1);
      if (n < 9) tick(CPB);
    end
    tick(3);
    check("tx_k_busy_last", o_tx_busy, 1);
    tick(1);
    check("tx_k_busy_drop", o_tx_busy, 0);
    wait_drain("tx_k_drain", 50);

    // TX burst: 6 pushes, 5 accepted, frames back to back
    o0 = ovf_cnt;
    queue_idle(2);
    for (int i = 1; i <= 5; i++) queue_frame(8'(i));
    queue_idle(8);
    i_com_strobe = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      i_com_data = 8'(i);
      tick(1);
    end
    i_com_strobe = 1'b0;
    tick(2);
    check("tx_overflow_pulses", ovf_cnt - o0, 1);
    check("tx_burst_busy", o_tx_busy, 1);
    wait_drain("tx_burst_drain", 600);
    check("tx_burst_busy_end", o_tx_busy, 0);

    // Bad stop bit
    s0 = strobe_cnt;
    f0 = ferr_cnt;
`ifdef DEBUG_UART_FRAME_CHECK_EN
    send_rx(8'h33, 1'b0, 0);
    tick(20 * CPB);
    check("ferr_no_strobe", strobe_cnt - s0, 0);
    check("ferr_pulses", ferr_cnt - f0, 1);
    i_uart_rx = 1'b1;
    tick(2 * CPB);
    send_rx(8'h3C, 1'b1, 1);
    tick(10);
    check("ferr_recover_count", strobe_cnt - s0, 1);
    check("ferr_recover_data", o_com_data, 8'h3C);
`else
    send_rx(8'h33, 1'b0, 1);
    i_uart_rx = 1'b1;
    tick(2 * CPB);
    check("nostop_strobe", strobe_cnt - s0, 1);
    check("nostop_data", o_com_data, 8'h33);
    check("nostop_ferr", ferr_cnt - f0, 0);
`endif

    // Reset mid TX bit 3 and mid RX bit 5
    s0 = strobe_cnt;
    fork
      send_rx(8'hE5, 1'b1, 0);
      begin
        tick(14);
        push(8'h4B);
        tick(37);
        rst_n = 1'b0;
        tick(1);
        check("midrst_uart_tx", o_uart_tx, 1);
        check("midrst_busy", o_tx_busy, 0);
        check("midrst_com_data", o_com_data, 0);
        rst_n = 1'b1;
      end
    join
    tick(10);
    check("midrst_no_rx_strobe", strobe_cnt - s0, 0);
    check("midrst_idle_line", o_uart_tx, 1);

    // Fresh full-duplex traffic after reset
    queue_idle(2);
    queue_frame(8'hC3);
    queue_idle(4);
    fork
      send_rx(8'h5A, 1'b1, 1);
      push(8'hC3);
    join
    wait_drain("post_rst_drain", 200);
    check("post_rst_rx_count", strobe_cnt - s0, 1);
    check("post_rst_rx_data", o_com_data, 8'h5A);
    check("post_rst_busy", o_tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debug_uart_phy.md
Name: debug_uart_phy

Overview:
- Byte-level serial PHY that feeds and drains the debug bus master's command stream.
- RX: deserialises 8N1 UART from the host into single-cycle byte strobes (`o_com_data`/`o_com_strobe`), which connect directly to the bus master's `i_com_*` inputs.
- TX: accepts the bus master's reply strobes (`"K"` acknowledges, read data) into a small FIFO and serialises them back to the host.
- Sits between the FPGA UART pins and the debug bus master.

Parameters:
- `CLKS_PER_BIT`, 417, clk cycles per UART bit (48 MHz / 115200); minimum 4.
- `TX_FIFO_DEPTH`, 4, TX FIFO entries; power of two, minimum 2.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous reset, active low
- `i_uart_rx`  in  1  asynchronous serial input, idles high
- `o_uart_tx`  out  1  serial output, idles high
- `o_com_data`  out  8  received byte, valid while `o_com_strobe` is high
- `o_com_strobe`  out  1  one-cycle pulse per received byte
- `i_com_data`  in  8  byte to transmit
- `i_com_strobe`  in  1  push `i_com_data` into the TX FIFO
- `o_frame_error`  out  1  one-cycle pulse on a bad stop bit (see Optional Feature)
- `o_tx_overflow`  out  1  one-cycle pulse when a push is dropped
- `o_tx_busy`  out  1  high while the FIFO is non-empty or a frame is in flight

Behaviour:
- Reset: one clock, reset synchronous active-low (`rst_n` sampled on posedge `clk`).
  - Output reset values: `o_uart_tx`=1, `o_com_data`=0, `o_com_strobe`=0, `o_frame_error`=0, `o_tx_overflow`=0, `o_tx_busy`=0.
  - RX synchroniser preset to 1, FIFO emptied, both FSMs to IDLE, all counters 0.
  - Reset mid-frame aborts immediately: `o_uart_tx` is high the cycle after reset is sampled, and the partial RX byte is discarded.
- RX path:
  - Two-flop synchroniser on `i_uart_rx`; all RX decisions use the synchronised value `rxs`.
  - FSM states: `RX_IDLE` -> `RX_START` -> `RX_DATA` -> `RX_STOP` -> `RX_IDLE`.
  - `RX_IDLE`: `rxs`==0 loads the bit counter and enters `RX_START`.
  - `RX_START`: wait `CLKS_PER_BIT/2` cycles (integer division) to mid start bit.
    - `rxs`==1 there is a glitch: return to `RX_IDLE`, no strobe.
    - `rxs`==0 there: enter `RX_DATA`.
  - `RX_DATA`: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, shifting into a register.
  - `RX_STOP`: sample once `CLKS_PER_BIT` cycles after bit 7.
    - `o_com_data` and `o_com_strobe`=1 are registered one cycle after this sample.
    - Return to `RX_IDLE` in the same cycle as the sample (half-bit early), so back-to-back frames with zero idle are received.
  - `o_com_data` holds its last value between strobes.
  - Bit counter is 3 bits; the clock-divider counter is `$clog2(CLKS_PER_BIT)` bits and wraps to 0 on reload.
- TX FIFO:
  - Write pointer, read pointer and count, each `$clog2(TX_FIFO_DEPTH)+1` bits; pointers wrap modulo depth.
  - A push is accepted if count < depth, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `o_tx_overflow` pulses the next cycle.
  - Simultaneous push and pop on a full FIFO: both happen and count is unchanged.
  - Push into an empty FIFO while `TX_IDLE`: the byte is popped no earlier than the next cycle. No bypass.
- TX FSM: `TX_IDLE` -> `TX_START` -> `TX_DATA` -> `TX_STOP` -> `TX_IDLE`.
  - `TX_IDLE` with count > 0: pop into the shift register and enter `TX_START`.
  - Each state lasts exactly `CLKS_PER_BIT` cycles per bit:
    - `TX_START`: `o_uart_tx`=0.
    - `TX_DATA`: 8 bits, LSB first.
    - `TX_STOP`: `o_uart_tx`=1 for one bit.
  - From `TX_STOP`, a pending byte is popped in the cycle `TX_STOP` ends, with no extra idle bit.
  - `o_uart_tx` is driven from a register (glitch-free).
- `o_tx_busy` = (count != 0) || (tx state != `TX_IDLE`), registered.
- RX and TX are fully independent. Full duplex is required; a host echo loop must not stall either side.

Optional Feature:
- Macro: `DEBUG_UART_FRAME_CHECK_EN`.
- Defined: at the `RX_STOP` sample, `rxs`==0 is a framing error.
  - The byte is discarded: no `o_com_strobe`, `o_com_data` unchanged.
  - `o_frame_error` pulses 1 cycle, in the cycle a strobe would have occurred.
  - The FSM waits in `RX_IDLE` for `rxs`==1 before accepting a new start bit, so a break is not re-detected as a start bit.
- Undefined: the stop bit value is ignored, every frame strobes, and `o_frame_error` is tied 0.

Test Plan (`CLKS_PER_BIT`=8, `TX_FIFO_DEPTH`=4):
- RX frame 0x52 (`"R"`) at exact rate -> single `o_com_strobe`, `o_com_data`=0x52, strobe high exactly 1 cycle. Then back-to-back frames 0x00, 0xFF with no idle gap -> two strobes, correct data.
- 3-cycle low glitch on `i_uart_rx` -> no strobe, FSM back in `RX_IDLE`; next valid frame 0xA5 received correctly.
- Push 0x4B (`"K"`) -> `o_uart_tx` low 8 cycles (start), then bits 1,1,0,1,0,0,1,0 at 8 cycles each, then high 8 cycles; `o_tx_busy` drops after the stop bit.
- Push 6 bytes 0x01..0x06 in consecutive cycles while idle:
  - first byte is popped after 1 cycle; 0x01..0x05 are accepted;
  - 0x06 is dropped with one `o_tx_overflow` pulse;
  - 0x01..0x05 are transmitted in order with no inter-frame idle.
- Frame 0x33 with stop bit 0, then line held low for 20 bits:
  - macro defined: no strobe, one `o_frame_error` pulse, no spurious frames until the line returns high;
  - macro undefined: strobe with 0x33.
- Assert `rst_n`=0 mid TX data bit 3 and mid RX bit 5 -> `o_uart_tx`=1 the next cycle, FIFO empty, no RX strobe; fresh frames after release behave normally.
